// File: rtl/xres_reset_sequencer_if.sv
// Pad-reset sequencer bus: filtered pad level and controls in, sequenced resets and status out.
interface xres_reset_sequencer_if #(
   parameter int NUM_DOMAINS = 3
);
   logic                   XRES_H_N;
   logic                   ENABLE;
   logic                   GLITCH_CLR;
   logic [NUM_DOMAINS-1:0] RST_N_OUT;
   logic                   RESET_ACTIVE;
   logic [1:0]             STATE;
   logic [7:0]             GLITCH_CNT;

   // Driver side: supplies pad level and controls, observes resets and status.
   modport master (
      output XRES_H_N, ENABLE, GLITCH_CLR,
      input  RST_N_OUT, RESET_ACTIVE, STATE, GLITCH_CNT
   );

   // Sequencer side.
   modport slave (
      input  XRES_H_N, ENABLE, GLITCH_CLR,
      output RST_N_OUT, RESET_ACTIVE, STATE, GLITCH_CNT
   );
endinterface

// File: rtl/xres_reset_sequencer.sv
// XRES reset sequencer: synchronizes and debounces the pad reset level, holds
// reset for a minimum time, then releases the core reset domains one by one.
module xres_reset_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_ASSERT      = 32,
   parameter int STAGE_GAP       = 4,
   parameter int NUM_DOMAINS     = 3,
   parameter int CNT_W           = 8
) (
   input  logic                   CLK,
   input  logic                   RESET_B,
   xres_reset_sequencer_if.slave  bus
);

   localparam int DOM_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIN_LIMIT  = CNT_W'(MIN_ASSERT);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [DOM_W-1:0] DOM_LAST   = DOM_W'(NUM_DOMAINS - 1);
   localparam logic [DOM_W-1:0] DOM_ZERO   = {DOM_W{1'b0}};
   localparam logic [DOM_W-1:0] DOM_ONE    = DOM_W'(1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   // Input filtering state
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   filt_q, filt_d;
   logic [CNT_W-1:0]       dcnt_q, dcnt_d;
   logic [7:0]             glitch_cnt_q, glitch_cnt_d;
   logic                   sync_out_s;
   logic                   glitch_s;

   // Sequencing state
   state_t                 state_q, state_d;
   logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
   logic                   active_q, active_d;
   logic [CNT_W-1:0]       min_cnt_q, min_cnt_d;
   logic [CNT_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [DOM_W-1:0]       dom_idx_q, dom_idx_d;
   logic                   abort_s;

   assign sync_out_s = sync_q[SYNC_STAGES-1];

   // Synchronizer shift, debounce filter and glitch counter next-state.
   always_comb begin
      sync_d       = {sync_q[SYNC_STAGES-2:0], bus.XRES_H_N};
      filt_d       = filt_q;
      dcnt_d       = dcnt_q;
      glitch_s     = 1'b0;
      glitch_cnt_d = glitch_cnt_q;

      if (sync_out_s != filt_q) begin
         if (dcnt_q == DEB_LAST) begin
            filt_d = sync_out_s;
            dcnt_d = CNT_ZERO;
         end else begin
            dcnt_d = dcnt_q + CNT_ONE;
         end
      end else if (dcnt_q != CNT_ZERO) begin
         // Level returned before the filter committed: a rejected pulse.
         dcnt_d   = CNT_ZERO;
         glitch_s = 1'b1;
      end else begin
         dcnt_d = CNT_ZERO;
      end

      // Clear takes priority over a glitch recorded on the same edge.
      if (bus.GLITCH_CLR) begin
         glitch_cnt_d = 8'd0;
      end else if (glitch_s && (glitch_cnt_q != 8'hFF)) begin
         glitch_cnt_d = glitch_cnt_q + 8'd1;
      end else begin
         glitch_cnt_d = glitch_cnt_q;
      end
   end

   // Registers for the synchronizer, debounce filter and glitch counter.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         sync_q       <= {SYNC_STAGES{1'b0}};
         filt_q       <= 1'b0;
         dcnt_q       <= CNT_ZERO;
         glitch_cnt_q <= 8'd0;
      end else begin
         sync_q       <= sync_d;
         filt_q       <= filt_d;
         dcnt_q       <= dcnt_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign abort_s = (!filt_q) || (!bus.ENABLE);

   // Sequencer next-state: minimum hold, staged release, abort back to reset.
   always_comb begin
      state_d   = state_q;
      rst_n_d   = rst_n_q;
      min_cnt_d = min_cnt_q;
      gap_cnt_d = gap_cnt_q;
      dom_idx_d = dom_idx_q;

      case (state_q)
         ST_ASSERT: begin
            rst_n_d = {NUM_DOMAINS{1'b0}};
            if (min_cnt_q != CNT_MAX) begin
               min_cnt_d = min_cnt_q + CNT_ONE;
            end else begin
               min_cnt_d = min_cnt_q;
            end
            if (filt_q && bus.ENABLE && (min_cnt_q >= MIN_LIMIT)) begin
               state_d   = ST_RELEASE;
               gap_cnt_d = CNT_ZERO;
               dom_idx_d = DOM_ZERO;
            end else begin
               state_d = ST_ASSERT;
            end
         end
         ST_RELEASE: begin
            if (abort_s) begin
               state_d   = ST_ASSERT;
               rst_n_d   = {NUM_DOMAINS{1'b0}};
               min_cnt_d = CNT_ZERO;
               gap_cnt_d = CNT_ZERO;
               dom_idx_d = DOM_ZERO;
            end else if (gap_cnt_q == GAP_LAST) begin
               rst_n_d[dom_idx_q] = 1'b1;
               gap_cnt_d          = CNT_ZERO;
               if (dom_idx_q == DOM_LAST) begin
                  state_d   = ST_RUN;
                  dom_idx_d = dom_idx_q;
               end else begin
                  state_d   = ST_RELEASE;
                  dom_idx_d = dom_idx_q + DOM_ONE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            if (abort_s) begin
               state_d   = ST_ASSERT;
               rst_n_d   = {NUM_DOMAINS{1'b0}};
               min_cnt_d = CNT_ZERO;
               gap_cnt_d = CNT_ZERO;
               dom_idx_d = DOM_ZERO;
            end else begin
               rst_n_d = {NUM_DOMAINS{1'b1}};
            end
         end
         default: begin
            // Unreachable encoding: fall back to full reset.
            state_d   = ST_ASSERT;
            rst_n_d   = {NUM_DOMAINS{1'b0}};
            min_cnt_d = CNT_ZERO;
            gap_cnt_d = CNT_ZERO;
            dom_idx_d = DOM_ZERO;
         end
      endcase

      active_d = (state_d != ST_RUN);
   end

   // Sequencer state and registered reset/status outputs.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q   <= ST_ASSERT;
         rst_n_q   <= {NUM_DOMAINS{1'b0}};
         active_q  <= 1'b1;
         min_cnt_q <= CNT_ZERO;
         gap_cnt_q <= CNT_ZERO;
         dom_idx_q <= DOM_ZERO;
      end else begin
         state_q   <= state_d;
         rst_n_q   <= rst_n_d;
         active_q  <= active_d;
         min_cnt_q <= min_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         dom_idx_q <= dom_idx_d;
      end
   end

   assign bus.RST_N_OUT    = rst_n_q;
   assign bus.RESET_ACTIVE = active_q;
   assign bus.STATE        = state_q;
   assign bus.GLITCH_CNT   = glitch_cnt_q;

endmodule
